// File: rtl/rfs_wifi_mem_stream_master.sv
// rfs_wifi_mem_stream_master
//
// Avalon-MM master that moves 32-bit word streams between the RFS WiFi
// datapath and a single-port on-chip memory. The memory has a fixed 1-cycle
// read latency and no waitrequest.
//   WRITE command : drains the snk_* valid/ready stream into memory.
//   READ command  : fetches memory words onto the src_* valid/ready stream.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_dir                         0 = WRITE, 1 = READ
//   cmd_addr, cmd_len               start word address, word count
//   snk_valid/snk_ready/snk_data    WRITE data stream (sink)
//   src_valid/src_ready/src_data    READ data stream (source)
//   avm_*                           Avalon-MM master toward the memory slave
//   done                            one-cycle pulse when a command completes
//   err                             one-cycle pulse when a command is rejected
//
// Build option
//   RFS_WIFI_MEM_MASTER_WRAP_EN : ring-buffer addressing. Addresses wrap from
//   DEPTH-1 to 0 and out-of-range start addresses are reduced modulo DEPTH.
//   When undefined, a command that would leave the memory is rejected with err.

module rfs_wifi_mem_stream_master #(
  parameter int unsigned DEPTH  = 32500,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [14:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic [14:0]       avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = 1;

`ifdef RFS_WIFI_MEM_MASTER_WRAP_EN
  function automatic logic [14:0] next_addr(input logic [14:0] a);
    return (a == 15'(DEPTH - 1)) ? 15'd0 : a + 15'd1;
  endfunction

  // A 15-bit address is below 2*DEPTH, so one subtraction is a full modulo.
  function automatic logic [14:0] reduce_addr(input logic [14:0] a);
    return (32'(a) >= DEPTH) ? 15'(32'(a) - DEPTH) : a;
  endfunction
`else
  function automatic logic [14:0] next_addr(input logic [14:0] a);
    return a + 15'd1;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [14:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               err_q;

  logic               cmd_fire;
  logic               cmd_bad;
  logic [14:0]        start_addr;
  logic               snk_fire;
  logic               rd_issue;
  logic               pop;

  logic               wr_vld_p1;
  logic [14:0]        wr_addr_p1;
  logic [DATA_W-1:0]  wr_data_p1;
  logic               rd_vld_p1;

  logic [DATA_W-1:0]  fifo_mem [2];
  logic               fifo_wp, fifo_rp;
  logic [1:0]         fifo_cnt;

  assign cmd_ready = (state_q == S_IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign snk_ready = (state_q == S_WRITE) && (rem_q != '0);
  assign snk_fire  = snk_valid & snk_ready;
  assign src_valid = (state_q == S_READ) && (fifo_cnt != 2'd0);
  assign pop       = src_valid & src_ready;

`ifdef RFS_WIFI_MEM_MASTER_WRAP_EN
  assign cmd_bad    = 1'b0;
  assign start_addr = reduce_addr(cmd_addr);
`else
  assign cmd_bad    = (32'(cmd_addr) >= DEPTH) || ((32'(cmd_addr) + 32'(cmd_len)) > DEPTH);
  assign start_addr = cmd_addr;
`endif

  // Occupancy plus in-flight reads never exceeds the 2-entry FIFO, so a
  // returning word always has a slot and no backpressure reaches memory.
  assign rd_issue = (state_q == S_READ) && (rem_q != '0) &&
                    ((3'(fifo_cnt) + 3'(rd_vld_p1) - 3'(pop)) < 3'd2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else if (!cmd_bad) begin
            addr_d  = start_addr;
            rem_d   = cmd_len;
            state_d = cmd_dir ? S_READ : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (snk_fire) begin
          addr_d = next_addr(addr_q);
          rem_d  = rem_q - LEN_ONE;
        end
        // The last strobe is on the bus while rem_q is already 0.
        if (rem_q == '0) state_d = S_DONE;
      end
      S_READ: begin
        if (rd_issue) begin
          addr_d = next_addr(addr_q);
          rem_d  = rem_q - LEN_ONE;
        end
        // Leave as soon as the final pop empties the FIFO, so done lands
        // the cycle after the last source handshake.
        if ((rem_q == '0) && !rd_vld_p1 && (fifo_cnt == 2'(pop)))
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= cmd_fire && (cmd_len != '0) && cmd_bad;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  // ---- stage p0 -> p1 : registered write strobe, read in flight ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_vld_p1 <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      wr_vld_p1 <= snk_fire;
      rd_vld_p1 <= rd_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (snk_fire) begin
      wr_addr_p1 <= addr_q;
      wr_data_p1 <= snk_data;
    end
  end

  // ---- stage p1 -> FIFO : read data captured one cycle after issue ----
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (rd_vld_p1) fifo_wp <= ~fifo_wp;
      if (pop)       fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(rd_vld_p1) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1) fifo_mem[fifo_wp] <= avm_readdata;
  end

  // Write strobes and read issues never overlap: the two come from
  // different states separated by DONE/IDLE.
  assign avm_chipselect = wr_vld_p1 | rd_issue;
  assign avm_write      = wr_vld_p1;
  assign avm_address    = wr_vld_p1 ? wr_addr_p1 : (rd_issue ? addr_q : 15'd0);
  assign avm_writedata  = wr_vld_p1 ? wr_data_p1 : '0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;
  assign src_data       = src_valid ? fifo_mem[fifo_rp] : '0;
  assign done           = (state_q == S_DONE);
  assign err            = err_q;

endmodule

// File: tb/tb_rfs_wifi_mem_stream_master.sv
module tb_rfs_wifi_mem_stream_master;

  localparam int DEPTH = 32500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [14:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [31:0] snk_data = '0;
  logic        src_valid;
  logic        src_ready = 1'b0;
  logic [31:0] src_data;
  logic [14:0] avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_clken;
  logic [31:0] avm_readdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  rfs_wifi_mem_stream_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_clken(avm_clken),
    .avm_readdata(avm_readdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, 1-cycle read latency.
  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
    if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_snk_ready"}, snk_ready, 0);
    check({tag, "_src_valid"}, src_valid, 0);
    check({tag, "_src_data"}, src_data, 0);
    check({tag, "_cs"}, avm_chipselect, 0);
    check({tag, "_we"}, avm_write, 0);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_wdata"}, avm_writedata, 0);
    check({tag, "_be"}, avm_byteenable, 4'hF);
    check({tag, "_clken"}, avm_clken, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_write(input logic [14:0] a, input int len, input logic [31:0] base);
    int  k = 0;
    int  nb = 0;
    bit  seen = 0;
    cmd_valid = 1; cmd_dir = 0; cmd_addr = a; cmd_len = 16'(len);
    @(negedge clk);
    nxt();
    cmd_valid = 0;
    for (int c = 0; c < len + 10 && !seen; c++) begin
      snk_valid = (nb < len);
      snk_data  = base + 32'(nb);
      @(negedge clk);
      if (avm_chipselect && avm_write) begin
        check("wr_addr", avm_address, 32'((int'(a) + k) % DEPTH));
        check("wr_data", avm_writedata, base + 32'(k));
        k++;
      end
      if (snk_valid && snk_ready) nb++;
      if (done) seen = 1;
      nxt();
    end
    snk_valid = 0;
    check("wr_count", 32'(k), 32'(len));
    check("wr_done_seen", 32'(seen), 1);
  endtask

  task automatic do_read(input logic [14:0] a, input int len, input logic [31:0] base,
                         input logic [3:0] pat, input string tag);
    int issued = 0;
    int popped = 0;
    int maxo = 0;
    int last_pop = -1;
    int done_c = -1;
    cmd_valid = 1; cmd_dir = 1; cmd_addr = a; cmd_len = 16'(len);
    src_ready = pat[0];
    @(negedge clk);
    nxt();
    cmd_valid = 0;
    for (int c = 1; c < 200 && done_c < 0; c++) begin
      src_ready = pat[c % 4];
      @(negedge clk);
      if (issued - popped > maxo) maxo = issued - popped;
      if (avm_chipselect && !avm_write) begin
        check({tag, "_raddr"}, avm_address, 32'((int'(a) + issued) % DEPTH));
        issued++;
      end
      if (src_valid && src_ready) begin
        check({tag, "_data"}, src_data, base + 32'(popped));
        popped++;
        last_pop = c;
      end
      if (done) done_c = c;
      nxt();
    end
    src_ready = 0;
    check({tag, "_issued"}, 32'(issued), 32'(len));
    check({tag, "_popped"}, 32'(popped), 32'(len));
    check({tag, "_done_cycle"}, 32'(done_c), 32'(last_pop + 1));
    check({tag, "_occ_le2"}, 32'(maxo <= 2), 1);
  endtask

  initial begin
    // Reset state
    nxt(); nxt();
    reset = 0;
    @(negedge clk);
    check_reset_vals("rst");
    nxt();

    // WRITE 0x10 len 4, back-to-back sink words A0..A3
    cmd_valid = 1; cmd_dir = 0; cmd_addr = 15'h10; cmd_len = 16'd4;
    @(negedge clk);
    check("w0_cmd_ready", cmd_ready, 1);
    check("w0_snk_ready", snk_ready, 0);
    nxt();
    cmd_valid = 0;
    for (int c = 1; c <= 7; c++) begin
      snk_valid = (c <= 4);
      snk_data  = 32'hA0 + 32'(c - 1);
      @(negedge clk);
      check("w_snk_ready", snk_ready, 32'(c <= 4));
      check("w_cs", avm_chipselect, 32'(c >= 2 && c <= 5));
      check("w_we", avm_write, 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        check("w_addr", avm_address, 32'h10 + 32'(c - 2));
        check("w_wdata", avm_writedata, 32'hA0 + 32'(c - 2));
      end
      check("w_done", done, 32'(c == 6));
      check("w_cmd_ready", cmd_ready, 32'(c == 7));
      nxt();
    end
    snk_valid = 0;

    // READ 0x10 len 4, src_ready held high
    cmd_valid = 1; cmd_dir = 1; cmd_addr = 15'h10; cmd_len = 16'd4; src_ready = 1;
    @(negedge clk);
    nxt();
    cmd_valid = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("r_cs", avm_chipselect, 32'(c <= 4));
      check("r_we", avm_write, 0);
      if (c <= 4) check("r_addr", avm_address, 32'h10 + 32'(c - 1));
      check("r_src_valid", src_valid, 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("r_src_data", src_data, 32'hA0 + 32'(c - 3));
      check("r_done", done, 32'(c == 7));
      nxt();
    end
    src_ready = 0;

    // READ len 8 with src_ready pattern 1,0,0,1
    do_write(15'h100, 8, 32'hC0DE_0000);
    do_read(15'h100, 8, 32'hC0DE_0000, 4'b1001, "r8");

    // Zero-length command
    cmd_valid = 1; cmd_dir = 0; cmd_addr = 15'd5; cmd_len = 16'd0;
    @(negedge clk);
    nxt();
    cmd_valid = 0;
    @(negedge clk);
    check("z_done", done, 1);
    check("z_cs", avm_chipselect, 0);
    check("z_cmd_ready", cmd_ready, 0);
    check("z_snk_ready", snk_ready, 0);
    nxt();
    @(negedge clk);
    check("z_done_clr", done, 0);
    check("z_cmd_ready_back", cmd_ready, 1);
    nxt();

`ifdef RFS_WIFI_MEM_MASTER_WRAP_EN
    // Ring-buffer: 32498, 32499, 0, 1
    do_write(15'd32498, 4, 32'hD000_0000);
`else
    // Out of range: rejected, no memory access even with sink data offered
    cmd_valid = 1; cmd_dir = 0; cmd_addr = 15'd32498; cmd_len = 16'd4;
    @(negedge clk);
    nxt();
    cmd_valid = 0; snk_valid = 1; snk_data = 32'hDEAD;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("e_err", err, 32'(c == 1));
      check("e_cmd_ready", cmd_ready, 1);
      check("e_snk_ready", snk_ready, 0);
      check("e_cs", avm_chipselect, 0);
      check("e_done", done, 0);
      nxt();
    end
    snk_valid = 0;
    // Start address beyond the memory
    cmd_valid = 1; cmd_dir = 1; cmd_addr = 15'd32600; cmd_len = 16'd1;
    @(negedge clk);
    nxt();
    cmd_valid = 0;
    @(negedge clk);
    check("e2_err", err, 1);
    check("e2_cs", avm_chipselect, 0);
    nxt();
    // Exact fit up to the last word is legal
    do_write(15'd32496, 4, 32'hE000_0000);
`endif

    // Reset in the middle of a READ len 16
    do_write(15'h200, 16, 32'h5000_0000);
    do_write(15'h300, 3, 32'h7700_0000);
    cmd_valid = 1; cmd_dir = 1; cmd_addr = 15'h200; cmd_len = 16'd16; src_ready = 1;
    @(negedge clk);
    nxt();
    cmd_valid = 0;
    repeat (5) nxt();
    @(negedge clk);
    check("mr_src_valid_before", src_valid, 1);
    reset = 1;
    nxt();
    reset = 0;
    @(negedge clk);
    check_reset_vals("mr");
    for (int c = 0; c < 3; c++) begin
      nxt();
      @(negedge clk);
      check("mr_no_done", done, 0);
      check("mr_no_cs", avm_chipselect, 0);
    end
    nxt();
    src_ready = 0;
    do_read(15'h300, 3, 32'h7700_0000, 4'b1111, "pr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfs_wifi_mem_stream_master.md
# rfs_wifi_mem_stream_master

- Avalon-MM master that moves word streams between the RFS WiFi datapath and the 32-bit single-port on-chip memory (32500 words, 15-bit word address, fixed 1-cycle read latency, no waitrequest).
- A command selects the direction, start address and length:
  - WRITE: the block drains a valid/ready sink stream into memory.
  - READ: the block fetches memory words onto a valid/ready source stream.
- Sits between the packet buffers and the memory's slave port; it is the initiator side of that slave.

## Interface
Parameters:
- DEPTH, 32500, memory size in words; the last legal address is DEPTH-1.
- LEN_W, 16, width of the command length field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_dir  in  1  0 = WRITE (stream to memory), 1 = READ (memory to stream).
- cmd_addr  in  15  start word address.
- cmd_len  in  LEN_W  number of words to transfer.
- snk_valid / snk_ready / snk_data  in / out / in(32)  WRITE data stream.
- src_valid / src_ready / src_data  out / in / out(32)  READ data stream.
- avm_address  out  15  memory word address.
- avm_chipselect  out  1  memory access strobe.
- avm_write  out  1  write strobe; 0 with chipselect means read.
- avm_byteenable  out  4  always 4'hF.
- avm_writedata  out  32  write data.
- avm_clken  out  1  tied 1.
- avm_readdata  in  32  read data, valid one cycle after a read strobe.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a command is rejected.

## Operation
State machine:
- IDLE: cmd_ready=1. A cmd_valid&cmd_ready handshake latches addr, len and dir.
  - len=0 -> DONE.
  - Out of range -> err pulse, stay in IDLE.
  - Otherwise -> WRITE or READ.
- WRITE:
  - snk_ready=1 while remaining>0.
  - Each sink handshake registers one memory write at the current address, then increments the address and decrements remaining.
  - remaining reaching 0 -> DONE.
- READ:
  - A 2-entry output FIFO drives src_*.
  - A read is issued only when (FIFO occupancy + reads in flight − pop this cycle) < 2 and remaining>0.
  - Returned avm_readdata is pushed into the FIFO one cycle after issue.
  - After the last issue, the block waits until the FIFO is empty and nothing is in flight, then -> DONE.
- DONE: done=1 for one cycle -> IDLE.

Other rules:
- Address arithmetic is 15-bit, modulo DEPTH (see Configuration).
- src_data order equals the address order. No data is dropped or duplicated under any src_ready pattern.
- snk_ready=0 and src_valid=0 outside WRITE and READ respectively.
- Reset mid-operation: the command is aborted, the FIFO is flushed, and done is not pulsed.

## Timing
- Reset values: cmd_ready=1; all other outputs 0 except avm_byteenable=4'hF and avm_clken=1.
- WRITE:
  - Command handshake in cycle 0 -> snk_ready=1 from cycle 1.
  - A sink beat in cycle t -> avm_chipselect=avm_write=1 in cycle t+1.
  - done is asserted the cycle after the last write strobe.
  - Throughput is 1 word/cycle.
- READ:
  - Command handshake in cycle 0 -> first read strobe in cycle 1 -> src_valid first asserted in cycle 3.
  - With src_ready held high, one word per cycle is sustained.
  - done is asserted the cycle after the last src handshake.
- err is asserted the cycle after the rejected handshake. cmd_ready stays 1 during the err pulse.
- cmd_ready=0 from the cycle after acceptance through the DONE cycle.

## Configuration
- RFS_WIFI_MEM_MASTER_WRAP_EN defined:
  - Ring-buffer mode: an address incremented past DEPTH-1 wraps to 0.
  - No command is rejected for range; cmd_addr ≥ DEPTH is reduced modulo DEPTH.
- Not defined:
  - A command with cmd_addr ≥ DEPTH, or cmd_addr+cmd_len > DEPTH, is rejected with err.
  - No memory access occurs for a rejected command.

## Test plan
- WRITE addr=0x0010 len=4, sink words 0xA0..0xA3 back-to-back -> write strobes at 0x10..0x13 in 4 consecutive cycles with matching data; one done pulse the cycle after the last strobe.
- READ addr=0x0010 len=4 with src_ready=1 -> src_valid from cycle 3 for 4 consecutive cycles, data 0xA0..0xA3, done on the following cycle.
- READ len=8 with src_ready toggling 1,0,0,1,… -> all 8 words are delivered in order with no loss; FIFO occupancy never exceeds 2.
- cmd_len=0 -> no avm_chipselect; done pulses the cycle after the handshake.
- Without WRAP_EN: addr=32498 len=4 -> err pulse and no memory access. With WRAP_EN: the same command writes 32498, 32499, 0, 1.
- Assert reset in the middle of a READ len=16 -> all outputs at reset values the next cycle; a new READ afterwards returns correct data from its start address.
